// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EXE stage. It does one radix-2
//   step per cycle and holds in_ready low while busy, which stalls the stage.
//   Operands come from the ID/EXE register. The result goes toward EXE/MEM
//   through a valid/ready handshake.
// Ports
//   clk, resetn          rising-edge clock, synchronous active-low reset
//   flush                kill any in-flight op (redirect)
//   in_valid/in_ready    operand handshake; in_ready = unit idle
//   op                   funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   src_a, src_b, rd_in  rs1/rs2 values and destination register
//   out_valid/out_ready  result handshake; out_valid = result waiting
//   result, rd_out       registered result and its destination register
module exe_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_LENGTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [REG_LENGTH-1:0] rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [REG_LENGTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, stateNext;
    logic [CW-1:0]       counter;
    logic [2:0]          opReg;
    logic [REG_LENGTH-1:0] rdReg;
    logic                negQ, negR;
    logic [W-1:0]        opnd;
    // Mul: {partial sum, multiplier}. Div: {partial remainder, dividend/quotient}.
    logic [2*W:0]        acc;

    // operand decode
    logic         aSigned, bSigned, aNeg, bNeg, isDiv, divZero, divOvf, accept, lastStep;
    logic [W-1:0] magA, magB;

    // one iteration and final fixup
    logic [W:0]     sumHi, addend, trial;
    logic [2*W:0]   shifted, accStep;
    logic [2*W-1:0] prodFix;
    logic [W-1:0]   quoFix, remFix, finalResult;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign lastStep  = (counter == CW'(1));

    always_comb begin
        isDiv   = op[2];
        aSigned = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        bSigned = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        aNeg    = aSigned && src_a[W-1];
        bNeg    = bSigned && src_b[W-1];
        magA    = aNeg ? -src_a : src_a;
        magB    = bNeg ? -src_b : src_b;
        divZero = isDiv && (src_b == '0);
        divOvf  = ((op == 3'd4) || (op == 3'd6)) &&
                  (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
    end

    always_comb begin
        // shift-add multiply step
        addend  = acc[0] ? {1'b0, opnd} : '0;
        sumHi   = acc[2*W:W] + addend;
        // restoring divide step; the partial remainder needs W+1 bits after the shift
        shifted = {acc[2*W-1:0], 1'b0};
        trial   = shifted[2*W:W] - {1'b0, opnd};
        if (opReg[2]) begin
            if (shifted[2*W:W] < {1'b0, opnd})
                accStep = shifted;
            else
                accStep = {trial, shifted[W-1:1], 1'b1};
        end else begin
            accStep = {sumHi, acc[W-1:0]} >> 1;
        end

        prodFix = negQ ? -accStep[2*W-1:0] : accStep[2*W-1:0];
        quoFix  = negQ ? -accStep[W-1:0]   : accStep[W-1:0];
        remFix  = negR ? -accStep[2*W-1:W] : accStep[2*W-1:W];
        case (opReg)
            3'd0:          finalResult = prodFix[W-1:0];
            3'd1, 3'd2, 3'd3: finalResult = prodFix[2*W-1:W];
            3'd4, 3'd5:    finalResult = quoFix;
            default:       finalResult = remFix;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = (divZero || divOvf) ? DONE : CALC;
            CALC:    if (lastStep) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            counter <= '0;
            opReg   <= '0;
            rdReg   <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (flush) begin
            counter <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    opReg   <= op;
                    rdReg   <= rd_in;
                    negQ    <= aNeg ^ bNeg;
                    negR    <= aNeg;
                    counter <= CW'(W);
                    if (isDiv) begin
                        opnd <= magB;
                        acc  <= {{(W+1){1'b0}}, magA};
                    end else begin
                        opnd <= magA;
                        acc  <= {{(W+1){1'b0}}, magB};
                    end
                    // Special cases finish at the accept edge; op[1] selects REM*.
                    if (divZero) begin
                        result <= op[1] ? src_a : '1;
                        rd_out <= rd_in;
                    end else if (divOvf) begin
                        result <= op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
                        rd_out <= rd_in;
                    end
                end
                CALC: begin
                    acc     <= accStep;
                    counter <= counter - CW'(1);
                    if (lastStep) begin
                        result <= finalResult;
                        rd_out <= rdReg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit
//   Directed bench for exe_muldiv_unit. A driver issues operations and queues
//   the hand-computed results. A monitor compares each result as it transfers.
//   The driver also checks latency, backpressure hold, flush and mid-op reset.
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, result;
    logic [4:0]  rd_in, rd_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];
    logic [4:0]  rdQ[$];
    string       nameQ[$];

    exe_muldiv_unit #(.DATA_WIDTH(32), .REG_LENGTH(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid && ready.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", result);
            end else begin
                string       n;
                logic [31:0] e;
                logic [4:0]  r;
                n = nameQ.pop_front();
                e = expQ.pop_front();
                r = rdQ.pop_front();
                chk({n, "_result"}, result, e);
                chk({n, "_rd"}, {27'b0, rd_out}, {27'b0, r});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic doAccept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        op = o; src_a = a; src_b = b; rd_in = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // expLat: rising edges after the accept edge until out_valid is seen.
    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int expLat);
        int n = 0;
        nameQ.push_back(name);
        expQ.push_back(exp);
        rdQ.push_back(rd);
        doAccept(o, a, b, rd);
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(expLat));
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src_a = '0; src_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_rd", {27'b0, rd_out}, 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // multiply
        issue("mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 32); waitIdle();
        issue("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 32); waitIdle();
        issue("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 32); waitIdle();
        issue("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 32); waitIdle();
        issue("mulh_m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 32); waitIdle();
        // divide
        issue("div",      3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 32); waitIdle();
        issue("rem",      3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 32); waitIdle();
        issue("divu",     3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 32); waitIdle();
        issue("remu",     3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 32); waitIdle();
        // special cases
        issue("divu_z",   3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 0); waitIdle();
        issue("remu_z",   3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 0); waitIdle();
        issue("div_z",    3'd4, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, 0); waitIdle();
        issue("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0); waitIdle();
        issue("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 0); waitIdle();

        // backpressure: result held for 10 cycles
        out_ready = 1'b0;
        issue("bp_divu", 3'd5, 32'd100, 32'd7, 5'd15, 32'd14, 32);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", result, 32'd14);
            chk("bp_hold_ctrl", {rd_out, 1'b0, out_valid, in_ready}, {5'd15, 1'b0, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'b0, out_valid, in_ready}, 32'b01);

        // flush at CALC cycle 12
        begin
            logic saw = 1'b0;
            doAccept(3'd0, 32'd3, 32'd5, 5'd16);
            repeat (11) @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            chk("flush_idle", {30'b0, out_valid, in_ready}, 32'b01);
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid) saw = 1'b1;
            end
            chk("flush_no_valid", 32'(saw), 32'd0);
        end

        // reset at cycle 20 of an op
        doAccept(3'd5, 32'd1000, 32'd3, 5'd17);
        repeat (19) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("midreset_result", result, 32'h0);
        chk("midreset_ctrl", {25'b0, rd_out, out_valid, in_ready}, 32'b01);
        issue("post_remu", 3'd7, 32'd1000, 32'd3, 5'd18, 32'd1, 32); waitIdle();
        issue("post_mul",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'd1, 32); waitIdle();

        begin
            int n = 0;
            while (expQ.size() != 0 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk("queue_drained", 32'(expQ.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
